mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM pipeline stage between the EX/MEM register and dmemory32. It turns decoded load/store ops
//  into word-wide RAM accesses, does load byte-lane extract and sign/zero extension, and runs a
//  2-cycle read-modify-write for SB/SH because the RAM has only a single-bit write enable.
//  It also holds the MEM/WB pipeline register feeding write-back.
// PARAMETERS
//  ADDR_W  14  RAM byte-address width (4096 words); higher address bits must be zero
// PORTS
//  clk_i           in   1   CPU clock (RAM is clocked on its inverse, so read data arrives same cycle)
//  rst_n_i         in   1   asynchronous, active-low reset
//  ex_valid_i      in   1   EX/MEM slot holds a real instruction
//  ex_op_i         in   4   MEM_NONE/LW/LH/LHU/LB/LBU/SW/SH/SB (mem_pkg encodings)
//  ex_addr_i       in   32  ALU result: byte address, or pass-through result when MEM_NONE
//  ex_wdata_i      in   32  store data (rt)
//  ex_rd_i         in   5   destination register
//  ex_regwrite_i   in   1   instruction writes the register file
//  stall_o         out  1   hold EX/MEM and earlier stages this cycle (combinational)
//  ram_wen_o       out  1   to dmemory32 ram_wen_i
//  ram_adr_o       out  14  to dmemory32 ram_adr_i (byte address, [1:0]=0)
//  ram_dat_o       out  32  to dmemory32 ram_dat_i
//  ram_dat_i       in   32  from dmemory32 ram_dat_o
//  wb_valid_o      out  1   MEM/WB slot valid
//  wb_regwrite_o   out  1   write-back enable
//  wb_rd_o         out  5   write-back register
//  wb_data_o       out  32  write-back data
//  addr_err_o      out  1   1-cycle pulse, aligned with wb_valid_o, for a misaligned/out-of-range access
// BEHAVIOUR
//  - Little-endian: byte k occupies bits [8k+7:8k]. Word index = ram_adr_o[13:2].
//  - Reset: state IDLE. All wb_* outputs, addr_err_o and ram_wen_o are 0, and ram_adr_o/ram_dat_o are 0.
//    Reset during MERGE abandons the write; ram_wen_o drops asynchronously.
//  - Error: LW/SW with addr[1:0]!=0, LH/LHU/SH with addr[0]!=0, or addr[31:ADDR_W]!=0.
//    No RAM write occurs, wb_regwrite_o<=0, addr_err_o<=1 and wb_valid_o<=1, all in 1 cycle.
//  - FSM IDLE (ex_valid_i=0 or bad op -> bubble: wb_valid_o<=0):
//    MEM_NONE   : wb_data_o<=ex_addr_i; 1-cycle latency; no RAM access.
//    LW/LH/LB/U : ram_adr_o=word addr and wen=0. Extract and extend ram_dat_i the same cycle, and
//                 register it into wb_data_o at the posedge. Latency 1; no stall.
//    SW         : wen=1 and ram_dat_o=ex_wdata_i in the same cycle. wb_regwrite_o<=0; latency 1.
//    SH/SB      : wen=0 (read), stall_o=1. Latch the merged word into merge_q (old word with lane(s)
//                 replaced by ex_wdata_i[7:0]/[15:0]) and latch the address. wb_valid_o<=0.
//                 Next state is MERGE.
//  - MERGE: ram_wen_o=1, ram_adr_o=latched addr, ram_dat_o=merge_q, stall_o=0.
//    ex_* inputs are ignored (they still show the held SB/SH). wb_valid_o<=1 and wb_regwrite_o<=0.
//    Next state is IDLE.
//  - stall_o is high only in IDLE while accepting a valid, aligned SH/SB.
//  - A store followed by a load to the same word is coherent: the RAM write lands on the negedge
//    before the load's read.
//  - wb_* outputs update only on posedge. Not-valid slots must not carry regwrite=1.
// STRUCTURE
//  - mem_pkg: MEM_* op encodings, state encodings, is_load/is_store/is_sub_word helpers.
//  - Sub-module mem_align (combinational): load lane select + sign/zero extend, and store merge.
//    Top level holds the FSM, merge_q, and the MEM/WB register.
// TESTING
//  1. Reset mid-run (rst_n_i=0 while in MERGE). Required: ram_wen_o=0 immediately, wb_valid_o=0,
//     and the RAM word is unchanged.
//  2. SW 0x11223344 @0x10, then LW @0x10. Required: wb_data_o=0x11223344 one cycle after the LW,
//     and no stall_o.
//  3. Word 0x11223344 @0x20, SB 0xAB @0x21. Required: stall_o=1 for exactly 1 cycle, and a
//     following LW gives 0x1122AB44.
//  4. Word 0x80FF7F01 @0x30. LB @0x32 -> 0xFFFFFFFF; LBU @0x32 -> 0x000000FF; LH @0x30 -> 0x00007F01;
//     LH @0x32 -> 0xFFFF80FF.
//  5. LW @0x22, SH @0x31, then SW @0x4000. Required: addr_err_o pulses once for each, no RAM write,
//     and wb_regwrite_o=0.
//  6. MEM_NONE with addr=0xDEADBEEF, rd=7 -> wb_data_o=0xDEADBEEF, wb_rd_o=7, wb_regwrite_o=1
//     next cycle. Also check back-to-back SB, SB to the same word: both bytes survive.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: op encodings, FSM states and op helpers.
package mem_pkg;

  localparam int MEM_ADDR_W = 14;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LW   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LHU  = 4'd3,
    MEM_LB   = 4'd4,
    MEM_LBU  = 4'd5,
    MEM_SW   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SB   = 4'd8
  } mem_op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } mau_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LW) || (op == MEM_LH) || (op == MEM_LHU) ||
           (op == MEM_LB) || (op == MEM_LBU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
  endfunction

  // Stores that need a read-modify-write because the RAM writes whole words only
  function automatic logic is_sub_word(input logic [3:0] op);
    return (op == MEM_SH) || (op == MEM_SB);
  endfunction

  // Anything above MEM_SB is an undefined op and is treated as a bubble
  function automatic logic is_known(input logic [3:0] op);
    return op <= MEM_SB;
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (op)
      MEM_LW, MEM_SW:          bad = (lo != 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: bad = lo[0];
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane handling: load lane select with sign/zero extension, and sub-word store merge.
module mem_align
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] ram_word,
  input  logic [15:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [7:0]  lanes [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Per-lane split of the old word and replacement of the lanes a SB/SH hits
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_new;

      assign lanes[gi] = ram_word[8*gi +: 8];
      assign lane_hit  = ((op == MEM_SB) && (byte_sel == 2'(gi))) ||
                         ((op == MEM_SH) && (byte_sel[1] == 1'(gi / 2)));
      // SB always writes data byte 0; SH writes data byte (lane mod 2)
      assign lane_new  = (op == MEM_SB) ? store_data[7:0] : store_data[8*(gi % 2) +: 8];
      assign merge_word[8*gi +: 8] = lane_hit ? lane_new : lanes[gi];
    end
  endgenerate

  // Load extract and extend
  always_comb begin
    sel_byte  = lanes[byte_sel];
    sel_half  = byte_sel[1] ? ram_word[31:16] : ram_word[15:0];
    load_data = ram_word;
    case (op)
      MEM_LH:  load_data = {{16{sel_half[15]}}, sel_half};
      MEM_LHU: load_data = {16'h0000, sel_half};
      MEM_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
      MEM_LBU: load_data = {24'h000000, sel_byte};
      default: load_data = ram_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: word RAM access, load extension, 2-cycle RMW for SB/SH, MEM/WB register.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ex_valid_i,
  input  logic [3:0]        ex_op_i,
  input  logic [31:0]       ex_addr_i,
  input  logic [31:0]       ex_wdata_i,
  input  logic [4:0]        ex_rd_i,
  input  logic              ex_regwrite_i,
  output logic              stall_o,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [31:0]       ram_dat_o,
  input  logic [31:0]       ram_dat_i,
  output logic              wb_valid_o,
  output logic              wb_regwrite_o,
  output logic [4:0]        wb_rd_o,
  output logic [31:0]       wb_data_o,
  output logic              addr_err_o
);

  mau_state_e        state_reg;
  logic [31:0]       merge_word_reg;
  logic [ADDR_W-1:0] merge_adr_reg;
  logic [4:0]        merge_rd_reg;

  logic              op_known;
  logic              op_mem;
  logic              access_err;
  logic              accept_ok;
  logic [ADDR_W-1:0] word_adr;
  logic [31:0]       load_data;
  logic [31:0]       merge_word;

  assign op_known   = is_known(ex_op_i);
  assign op_mem     = is_load(ex_op_i) || is_store(ex_op_i);
  assign access_err = op_mem && (is_misaligned(ex_op_i, ex_addr_i[1:0]) ||
                                 (|ex_addr_i[31:ADDR_W]));
  assign accept_ok  = (state_reg == ST_IDLE) && ex_valid_i && op_mem && !access_err;
  assign word_adr   = {ex_addr_i[ADDR_W-1:2], 2'b00};

  // Stall only the first (read) half of a sub-word store; reset forces it low
  assign stall_o = rst_n_i && accept_ok && is_sub_word(ex_op_i);

  mem_align u_align (
    .op         (ex_op_i),
    .byte_sel   (ex_addr_i[1:0]),
    .ram_word   (ram_dat_i),
    .store_data (ex_wdata_i[15:0]),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  // RAM port drive; gated by reset so an in-flight merge write is dropped at once
  always_comb begin
    ram_wen_o = 1'b0;
    ram_adr_o = '0;
    ram_dat_o = '0;
    if (rst_n_i) begin
      if (state_reg == ST_MERGE) begin
        ram_wen_o = 1'b1;
        ram_adr_o = merge_adr_reg;
        ram_dat_o = merge_word_reg;
      end else if (accept_ok) begin
        ram_adr_o = word_adr;
        if (ex_op_i == MEM_SW) begin
          ram_wen_o = 1'b1;
          ram_dat_o = ex_wdata_i;
        end
      end
    end
  end

  // FSM plus MEM/WB register; status bits default to a bubble each cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= ST_IDLE;
      merge_word_reg <= '0;
      merge_adr_reg  <= '0;
      merge_rd_reg   <= '0;
      wb_valid_o     <= 1'b0;
      wb_regwrite_o  <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      addr_err_o     <= 1'b0;
    end else begin
      wb_valid_o    <= 1'b0;
      wb_regwrite_o <= 1'b0;
      addr_err_o    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (ex_valid_i && op_known) begin
            if (access_err) begin
              wb_valid_o <= 1'b1;
              addr_err_o <= 1'b1;
              wb_rd_o    <= ex_rd_i;
            end else if (ex_op_i == MEM_NONE) begin
              wb_valid_o    <= 1'b1;
              wb_regwrite_o <= ex_regwrite_i;
              wb_rd_o       <= ex_rd_i;
              wb_data_o     <= ex_addr_i;
            end else if (is_load(ex_op_i)) begin
              wb_valid_o    <= 1'b1;
              wb_regwrite_o <= ex_regwrite_i;
              wb_rd_o       <= ex_rd_i;
              wb_data_o     <= load_data;
            end else if (ex_op_i == MEM_SW) begin
              wb_valid_o <= 1'b1;
              wb_rd_o    <= ex_rd_i;
            end else begin
              // SH/SB: the old word was read this cycle; keep the merged result for next cycle
              merge_word_reg <= merge_word;
              merge_adr_reg  <= word_adr;
              merge_rd_reg   <= ex_rd_i;
              state_reg      <= ST_MERGE;
            end
          end
        end
        ST_MERGE: begin
          wb_valid_o <= 1'b1;
          wb_rd_o    <= merge_rd_reg;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: word RAM stand-in, transaction-level reference model, per-cycle compare.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [3:0]  ex_op_i = '0;
  logic [31:0] ex_addr_i = '0;
  logic [31:0] ex_wdata_i = '0;
  logic [4:0]  ex_rd_i = '0;
  logic        ex_regwrite_i = 1'b0;
  logic        stall_o;
  logic        ram_wen_o;
  logic [13:0] ram_adr_o;
  logic [31:0] ram_dat_o;
  logic [31:0] ram_dat_i;
  logic        wb_valid_o;
  logic        wb_regwrite_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        addr_err_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    bit          valid;
    bit          regwrite;
    bit          err;
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;

  bit [31:0] tb_ram  [4096];
  bit [31:0] ref_mem [4096];
  bit [31:0] ram_rd;

  assign ram_dat_i = ram_rd;

  always #5 clk_i = ~clk_i;

  mem_access_unit dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .ex_valid_i    (ex_valid_i),
    .ex_op_i       (ex_op_i),
    .ex_addr_i     (ex_addr_i),
    .ex_wdata_i    (ex_wdata_i),
    .ex_rd_i       (ex_rd_i),
    .ex_regwrite_i (ex_regwrite_i),
    .stall_o       (stall_o),
    .ram_wen_o     (ram_wen_o),
    .ram_adr_o     (ram_adr_o),
    .ram_dat_o     (ram_dat_o),
    .ram_dat_i     (ram_dat_i),
    .wb_valid_o    (wb_valid_o),
    .wb_regwrite_o (wb_regwrite_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .addr_err_o    (addr_err_o)
  );

  // dmemory32 stand-in: clocked on the falling edge, read-before-write
  always @(negedge clk_i) begin
    if (ram_wen_o) tb_ram[ram_adr_o[13:2]] <= ram_dat_o;
    ram_rd <= tb_ram[ram_adr_o[13:2]];
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare process: checks the MEM/WB outputs against the expectation for this cycle
  always @(posedge clk_i) begin
    #3;
    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      ce = exp_q.pop_front();
      if (ce.cyc != cyc) check("model_sync", 32'(ce.cyc), 32'(cyc));
      check("wb_valid", 32'(wb_valid_o), 32'(ce.valid));
      check("addr_err", 32'(addr_err_o), 32'(ce.err));
      check("wb_regwrite", 32'(wb_regwrite_o), 32'(ce.valid && ce.regwrite));
      if (ce.valid) check("wb_rd", 32'(wb_rd_o), 32'(ce.rd));
      if (ce.valid && ce.regwrite) check("wb_data", wb_data_o, ce.data);
      $display("cyc %0d: wb_valid=%0b rw=%0b rd=%0d data=%h err=%0b", cyc, wb_valid_o,
               wb_regwrite_o, wb_rd_o, wb_data_o, addr_err_o);
    end
  end

  function automatic logic [31:0] align_mask(input logic [3:0] op);
    if (op == MEM_LW || op == MEM_SW) return 32'd3;
    if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return 32'd1;
    return 32'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = ref_mem[addr[13:2]] >> (8 * addr[1:0]);
    b  = sh[7:0];
    h  = sh[15:0];
    case (op)
      MEM_LB:  return {{24{b[7]}}, b};
      MEM_LBU: return {24'd0, b};
      MEM_LH:  return {{16{h[15]}}, h};
      MEM_LHU: return {16'd0, h};
      default: return ref_mem[addr[13:2]];
    endcase
  endfunction

  // Drive one instruction, predict its MEM/WB result, and follow through a merge cycle
  task automatic issue(input bit v, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input bit rw,
                       input bit lit_en, input logic [31:0] lit);
    exp_t        e;
    bit          is_mem, err, sub;
    logic [31:0] mask;
    @(posedge clk_i);
    #1;
    ex_valid_i = v; ex_op_i = op; ex_addr_i = addr; ex_wdata_i = wd;
    ex_rd_i = rd; ex_regwrite_i = rw;
    e = '{valid: 1'b0, regwrite: 1'b0, err: 1'b0, rd: rd, data: 32'd0, cyc: cyc + 1};
    is_mem = (op >= 4'd1) && (op <= 4'd8);
    err = is_mem && (((addr & align_mask(op)) != 0) || (addr >= 32'h4000));
    sub = 1'b0;
    if (v && op <= 4'd8) begin
      e.valid = 1'b1;
      if (err) begin
        e.err = 1'b1;
      end else if (op == MEM_NONE) begin
        e.regwrite = rw; e.data = addr;
      end else if (op >= 4'd1 && op <= 4'd5) begin
        e.regwrite = rw; e.data = model_load(op, addr);
      end else if (op == MEM_SW) begin
        ref_mem[addr[13:2]] = wd;
      end else begin
        sub  = 1'b1;
        mask = ((op == MEM_SB) ? 32'hFF : 32'hFFFF) << (8 * addr[1:0]);
        ref_mem[addr[13:2]] = (ref_mem[addr[13:2]] & ~mask) | ((wd << (8 * addr[1:0])) & mask);
      end
    end
    if (lit_en) check("model_lit", e.data, lit);
    if (sub) begin
      e.valid = 1'b0;
      exp_q.push_back(e);
      #1 check("stall_rmw", 32'(stall_o), 32'd1);
      @(posedge clk_i);
      #1;
      e.valid = 1'b1; e.cyc = cyc + 1;
      exp_q.push_back(e);
      #1 check("stall_merge", 32'(stall_o), 32'd0);
    end else begin
      exp_q.push_back(e);
      #1 check("stall_none", 32'(stall_o), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, MEM_NONE, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    logic [3:0]  op;
    logic [31:0] addr;

    // Reset state
    #2;
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_wb_regwrite", 32'(wb_regwrite_o), 32'd0);
    check("rst_addr_err", 32'(addr_err_o), 32'd0);
    check("rst_ram_wen", 32'(ram_wen_o), 32'd0);
    check("rst_ram_adr", 32'(ram_adr_o), 32'd0);
    check("rst_ram_dat", ram_dat_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    // Store then load, same word
    issue(1, MEM_SW, 32'h10, 32'h11223344, 5'd1, 1, 0, 32'd0);
    issue(1, MEM_LW, 32'h10, 32'd0, 5'd2, 1, 1, 32'h11223344);
    // Byte merge into an existing word
    issue(1, MEM_SW, 32'h20, 32'h11223344, 5'd3, 1, 0, 32'd0);
    issue(1, MEM_SB, 32'h21, 32'h000000AB, 5'd4, 1, 0, 32'd0);
    issue(1, MEM_LW, 32'h20, 32'd0, 5'd5, 1, 1, 32'h1122AB44);
    // Load extension
    issue(1, MEM_SW, 32'h30, 32'h80FF7F01, 5'd6, 1, 0, 32'd0);
    issue(1, MEM_LB, 32'h32, 32'd0, 5'd8, 1, 1, 32'hFFFFFFFF);
    issue(1, MEM_LBU, 32'h32, 32'd0, 5'd9, 1, 1, 32'h000000FF);
    issue(1, MEM_LH, 32'h30, 32'd0, 5'd10, 1, 1, 32'h00007F01);
    issue(1, MEM_LH, 32'h32, 32'd0, 5'd11, 1, 1, 32'hFFFF80FF);
    // Address errors: no writes may land
    issue(1, MEM_LW, 32'h22, 32'd0, 5'd12, 1, 0, 32'd0);
    issue(1, MEM_SH, 32'h31, 32'h0000BEEF, 5'd13, 1, 0, 32'd0);
    issue(1, MEM_SW, 32'h4000, 32'hCAFEF00D, 5'd14, 1, 0, 32'd0);
    issue(1, MEM_LW, 32'h30, 32'd0, 5'd15, 1, 1, 32'h80FF7F01);
    issue(1, MEM_LW, 32'h0, 32'd0, 5'd16, 1, 1, 32'h00000000);
    // Pass-through and back-to-back byte stores
    issue(1, MEM_NONE, 32'hDEADBEEF, 32'd0, 5'd7, 1, 1, 32'hDEADBEEF);
    issue(1, MEM_SW, 32'h40, 32'h00000000, 5'd17, 1, 0, 32'd0);
    issue(1, MEM_SB, 32'h41, 32'h00000055, 5'd18, 1, 0, 32'd0);
    issue(1, MEM_SB, 32'h42, 32'h00000066, 5'd19, 1, 0, 32'd0);
    issue(1, MEM_LW, 32'h40, 32'd0, 5'd20, 1, 1, 32'h00665500);

    // Reset during the merge cycle abandons the write
    issue(1, MEM_SW, 32'h50, 32'h5A5A5A5A, 5'd21, 1, 0, 32'd0);
    idle(2);
    @(posedge clk_i);
    #1;
    ex_valid_i = 1'b1; ex_op_i = MEM_SB; ex_addr_i = 32'h51; ex_wdata_i = 32'hFF;
    ex_rd_i = 5'd22; ex_regwrite_i = 1'b0;
    #1 check("rst_test_stall", 32'(stall_o), 32'd1);
    @(posedge clk_i);
    #1 check("merge_wen", 32'(ram_wen_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    check("rst_merge_wen", 32'(ram_wen_o), 32'd0);
    check("rst_merge_valid", 32'(wb_valid_o), 32'd0);
    ex_valid_i = 1'b0;
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    check("rst_merge_ram", tb_ram[20], ref_mem[20]);
    $display("reset during merge: word @0x50 = %h", tb_ram[20]);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 7) == 0)
        addr = 32'h4000 << $urandom_range(0, 17) | 32'($urandom_range(0, 3));
      else if (op == MEM_NONE)
        addr = $urandom;
      else
        addr = {24'd0, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      issue(($urandom_range(0, 9) != 0), op, addr, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 0, 32'd0);
    end

    idle(3);
    @(posedge clk_i);
    #5;
    check("exp_drain", 32'(exp_q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < 4096; i++) if (tb_ram[i] != ref_mem[i]) mism++;
    check("ram_final", 32'(mism), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
